alu_regfile: RTL and testbench

Datapath core of the single-cycle 8-bit CPU. It holds the eight-entry 8-bit register file, with two combinational read ports and one clocked write port. It also holds the combinational 8-bit ALU, which computes the write-back value and the ZERO flag used for branch decisions. Operand muxing, two's-complement negation, PC logic and instruction decode sit outside this block in the CPU top.

---
 rtl/alu_regfile_pkg.sv | 24 ++
 rtl/alu_regfile_alu.sv | 75 +++++++
 rtl/alu_regfile_reg_file.sv | 48 ++++
 rtl/alu_regfile.sv | 48 ++++
 tb/tb_alu_regfile.sv | 134 +++++++++++++
 5 files changed

// File: rtl/alu_regfile_pkg.sv
// Shared definitions for the CPU datapath core: widths, ALU operation
// codes and right-shift mode codes.
package alu_regfile_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int REG_N_DEF  = 8;
    localparam int ADDR_W     = 3;

    typedef enum logic [2:0] {
        ALU_FWD   = 3'b000,
        ALU_ADD   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_MUL   = 3'b100,
        ALU_SHIFT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        RS_LOGIC = 2'b00,
        RS_ARITH = 2'b01,
        RS_ROT   = 2'b10
    } rs_mode_e;

endpackage

// File: rtl/alu_regfile_alu.sv
// Combinational 8-bit ALU with forward/add/and/or/multiply/shift and a
// ZERO flag. Shift amount comes from DATA2; R/RS only matter for shifts.
module alu
    import alu_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] DATA1,
    input  logic [DATA_W-1:0] DATA2,
    input  logic [2:0]        SELECT,
    input  logic              R,
    input  logic [1:0]        RS,
    output logic [DATA_W-1:0] RESULT,
    output logic              ZERO
);

    localparam int SH_W = $clog2(DATA_W);

    logic              big_amt_s;
    logic [SH_W-1:0]   amt_s;
    logic [SH_W-1:0]   sat_amt_s;
    logic [DATA_W-1:0] shift_s;
    logic [2*DATA_W-1:0] rot_dbl_s;
    logic [DATA_W-1:0] result_s;

    // Shifter: any amount of DATA_W or more empties logical shifts and saturates the arithmetic one.
    always_comb begin
        big_amt_s = (DATA2 >= DATA_W[DATA_W-1:0]);
        amt_s     = DATA2[SH_W-1:0];
        if (big_amt_s) begin
            sat_amt_s = {SH_W{1'b1}};
        end else begin
            sat_amt_s = amt_s;
        end
        rot_dbl_s = {DATA1, DATA1} >> amt_s;
        shift_s   = {DATA_W{1'b0}};
        if (R == 1'b0) begin
            if (big_amt_s) begin
                shift_s = {DATA_W{1'b0}};
            end else begin
                shift_s = DATA1 << amt_s;
            end
        end else begin
            case (RS)
                RS_LOGIC: begin
                    if (big_amt_s) begin
                        shift_s = {DATA_W{1'b0}};
                    end else begin
                        shift_s = DATA1 >> amt_s;
                    end
                end
                RS_ARITH: shift_s = $unsigned($signed(DATA1) >>> sat_amt_s);
                RS_ROT:   shift_s = rot_dbl_s[DATA_W-1:0];
                default:  shift_s = {DATA_W{1'b0}};
            endcase
        end
    end

    // Operation select; unused and unknown codes produce zero.
    always_comb begin
        result_s = {DATA_W{1'b0}};
        case (SELECT)
            ALU_FWD:   result_s = DATA2;
            ALU_ADD:   result_s = DATA1 + DATA2;
            ALU_AND:   result_s = DATA1 & DATA2;
            ALU_OR:    result_s = DATA1 | DATA2;
            ALU_MUL:   result_s = DATA1 * DATA2;
            ALU_SHIFT: result_s = shift_s;
            default:   result_s = {DATA_W{1'b0}};
        endcase
        RESULT = result_s;
        ZERO   = (result_s == {DATA_W{1'b0}});
    end

endmodule

// File: rtl/alu_regfile_reg_file.sv
// Register file: REG_N entries, two combinational read ports, one clocked
// write port. r0 is an ordinary register. No write-to-read bypass.
module reg_file
    import alu_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_N  = REG_N_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] REGOUT1,
    output logic [DATA_W-1:0] REGOUT2,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic [DATA_W-1:0] IN
);

    logic [REG_N-1:0][DATA_W-1:0] regs_q;
    logic [REG_N-1:0][DATA_W-1:0] regs_d;

    // Next-state of the register array: update only the addressed entry on a write.
    always_comb begin
        regs_d = regs_q;
        if (WRITE) begin
            regs_d[INADDRESS] = IN;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register storage; synchronous reset takes priority over any write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports reflect stored contents only (old value during a write).
    always_comb begin
        REGOUT1 = regs_q[OUT1ADDRESS];
        REGOUT2 = regs_q[OUT2ADDRESS];
    end

endmodule

// File: rtl/alu_regfile.sv
// Datapath core of the single-cycle 8-bit CPU: register file plus ALU.
module alu_regfile
    import alu_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_N  = REG_N_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] REGOUT1,
    output logic [DATA_W-1:0] REGOUT2,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic [DATA_W-1:0] IN,
    input  logic [DATA_W-1:0] DATA1,
    input  logic [DATA_W-1:0] DATA2,
    input  logic [2:0]        SELECT,
    input  logic              R,
    input  logic [1:0]        RS,
    output logic [DATA_W-1:0] RESULT,
    output logic              ZERO
);

    reg_file #(.DATA_W(DATA_W), .REG_N(REG_N)) u_reg_file (
        .CLK         (CLK),
        .RESET       (RESET),
        .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS),
        .REGOUT1     (REGOUT1),
        .REGOUT2     (REGOUT2),
        .WRITE       (WRITE),
        .INADDRESS   (INADDRESS),
        .IN          (IN)
    );

    alu #(.DATA_W(DATA_W)) u_alu (
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .SELECT (SELECT),
        .R      (R),
        .RS     (RS),
        .RESULT (RESULT),
        .ZERO   (ZERO)
    );

endmodule

// File: tb/tb_alu_regfile.sv
// Directed self-checking bench for alu_regfile.
module tb_alu_regfile;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [2:0] OUT1ADDRESS, OUT2ADDRESS, INADDRESS;
    logic [7:0] REGOUT1, REGOUT2, IN, DATA1, DATA2, RESULT;
    logic       WRITE, R, ZERO;
    logic [2:0] SELECT;
    logic [1:0] RS;

    int checks = 0;
    int errors = 0;

    alu_regfile dut (
        .CLK(CLK), .RESET(RESET),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .REGOUT1(REGOUT1), .REGOUT2(REGOUT2),
        .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT),
        .R(R), .RS(RS), .RESULT(RESULT), .ZERO(ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic alu_chk(input string tag, input logic [2:0] sel, input logic [7:0] d1,
                           input logic [7:0] d2, input logic r, input logic [1:0] rs,
                           input logic [7:0] exp);
        SELECT = sel; DATA1 = d1; DATA2 = d2; R = r; RS = rs;
        #1;
        check(tag, RESULT, exp);
        check({tag, "_zero"}, {7'd0, ZERO}, {7'd0, (exp == 8'h00)});
    endtask

    initial begin
        RESET = 1'b1; WRITE = 1'b0; IN = 8'h00; INADDRESS = 3'd0;
        OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
        DATA1 = 8'h00; DATA2 = 8'h00; SELECT = 3'b000; R = 1'b0; RS = 2'b00;
        #2;
        tick();
        RESET = 1'b0;
        check("reset_r0", REGOUT1, 8'h00);

        // Write distinct values to all registers, read back, then reset.
        WRITE = 1'b1;
        for (int i = 0; i < 8; i++) begin
            INADDRESS = i[2:0]; IN = 8'h10 + 8'(i);
            tick();
        end
        WRITE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            OUT1ADDRESS = i[2:0]; OUT2ADDRESS = 3'(7 - i);
            #1;
            check("wr_rd1", REGOUT1, 8'h10 + 8'(i));
            check("wr_rd2", REGOUT2, 8'h17 - 8'(i));
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            OUT1ADDRESS = i[2:0]; OUT2ADDRESS = i[2:0];
            #1;
            check("rst_clr1", REGOUT1, 8'h00);
            check("rst_clr2", REGOUT2, 8'h00);
        end

        // Reset beats a simultaneous write.
        RESET = 1'b1; WRITE = 1'b1; IN = 8'hAA; INADDRESS = 3'd3;
        tick();
        RESET = 1'b0; WRITE = 1'b0;
        OUT1ADDRESS = 3'd3;
        #1;
        check("rst_prio", REGOUT1, 8'h00);

        // Write timing: old value before the edge, new value after.
        WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'h05; OUT1ADDRESS = 3'd1;
        #1;
        check("pre_edge", REGOUT1, 8'h00);
        tick();
        check("post_edge", REGOUT1, 8'h05);
        WRITE = 1'b0; IN = 8'hFF;
        tick();
        check("no_write", REGOUT1, 8'h05);
        WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'h11;
        tick();
        WRITE = 1'b0; OUT2ADDRESS = 3'd0;
        #1;
        check("r0_write", REGOUT2, 8'h11);
        OUT1ADDRESS = 3'd1;
        #1;
        check("r1_kept", REGOUT1, 8'h05);

        // ALU
        alu_chk("add_zero", 3'b001, 8'h05, 8'hFB, 1'b0, 2'b00, 8'h00);
        alu_chk("add_wrap", 3'b001, 8'hFF, 8'h02, 1'b0, 2'b00, 8'h01);
        alu_chk("and",      3'b010, 8'hF0, 8'h3C, 1'b0, 2'b00, 8'h30);
        alu_chk("or",       3'b011, 8'hF0, 8'h3C, 1'b0, 2'b00, 8'hFC);
        alu_chk("mul",      3'b100, 8'h10, 8'h11, 1'b0, 2'b00, 8'h10);
        alu_chk("fwd",      3'b000, 8'h55, 8'h7A, 1'b0, 2'b00, 8'h7A);
        alu_chk("sel110",   3'b110, 8'h55, 8'h7A, 1'b0, 2'b00, 8'h00);
        alu_chk("sel111",   3'b111, 8'h55, 8'h7A, 1'b0, 2'b00, 8'h00);
        alu_chk("add_xctl", 3'b001, 8'h12, 8'h34, 1'bx, 2'bxx, 8'h46);
        alu_chk("sll2",     3'b101, 8'h96, 8'd2, 1'b0, 2'b00, 8'h58);
        alu_chk("srl2",     3'b101, 8'h96, 8'd2, 1'b1, 2'b00, 8'h25);
        alu_chk("sra2",     3'b101, 8'h96, 8'd2, 1'b1, 2'b01, 8'hE5);
        alu_chk("ror2",     3'b101, 8'h96, 8'd2, 1'b1, 2'b10, 8'hA5);
        alu_chk("rs11",     3'b101, 8'h96, 8'd2, 1'b1, 2'b11, 8'h00);
        alu_chk("sll9",     3'b101, 8'h96, 8'd9, 1'b0, 2'b00, 8'h00);
        alu_chk("srl9",     3'b101, 8'h96, 8'd9, 1'b1, 2'b00, 8'h00);
        alu_chk("sra9",     3'b101, 8'h96, 8'd9, 1'b1, 2'b01, 8'hFF);
        alu_chk("sra9_pos", 3'b101, 8'h56, 8'd9, 1'b1, 2'b01, 8'h00);
        alu_chk("ror9",     3'b101, 8'h96, 8'd9, 1'b1, 2'b10, 8'h4B);
        alu_chk("sll7",     3'b101, 8'h96, 8'd7, 1'b0, 2'b00, 8'h00);
        alu_chk("srl7",     3'b101, 8'h96, 8'd7, 1'b1, 2'b00, 8'h01);
        alu_chk("sll8_big", 3'b101, 8'h01, 8'd8, 1'b0, 2'b00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
